// File: rtl/alu_pkg.sv
// Shared ALU definitions: CB-prefix shift operation encodings and the
// left/right decode bit of op543.
package alu_pkg;

  typedef enum logic [2:0] {
    RLC = 3'd0,
    RRC = 3'd1,
    RL  = 3'd2,
    RR  = 3'd3,
    SLA = 3'd4,
    SRA = 3'd5,
    SLL = 3'd6,
    SRL = 3'd7
  } shift_op_t;

  // op543 bit that selects direction: 0 = left, 1 = right
  localparam int unsigned SHIFT_DIR_BIT = 0;

endpackage

// File: rtl/alu_shifter_comb.sv
// Combinational Z80 rotate/shift unit. With ALU_SHIFTER_SLL_EN defined,
// op 110 inserts a 1 (undocumented SLL); otherwise it behaves as SLA.
module alu_shifter_comb
  import alu_pkg::*;
(
  input  logic [7:0] db,
  input  logic [2:0] op543,
  input  logic       cf_in,
  input  logic       shift_enable,
  output logic [7:0] result,
  output logic       cf
);

  logic w_ins;

  always_comb begin
    w_ins = 1'b0;
    case (shift_op_t'(op543))
      RLC:     w_ins = db[7];
      RRC:     w_ins = db[0];
      RL:      w_ins = cf_in;
      RR:      w_ins = cf_in;
      SLA:     w_ins = 1'b0;
      SRA:     w_ins = db[7];
`ifdef ALU_SHIFTER_SLL_EN
      SLL:     w_ins = 1'b1;
`else
      SLL:     w_ins = 1'b0;
`endif
      SRL:     w_ins = 1'b0;
      default: w_ins = 1'b0;
    endcase
  end

  always_comb begin
    result = db;
    cf     = cf_in;
    if (shift_enable) begin
      if (op543[SHIFT_DIR_BIT]) begin
        result = {w_ins, db[7:1]};
        cf     = db[0];
      end else begin
        result = {db[6:0], w_ins};
        cf     = db[7];
      end
    end
  end

endmodule

// File: rtl/alu_in_shifter.sv
// A-Z80 ALU input shifter: one registered stage between the data bus and
// the nibble datapath. Optional SLL behaviour via macro ALU_SHIFTER_SLL_EN.
module alu_in_shifter
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] db,
  input  logic [2:0] op543,
  input  logic       cf_in,
  input  logic       shift_enable,
  output logic [3:0] db_in_low,
  output logic [3:0] db_in_high,
  output logic       cf_out
);

  logic [7:0] w_result_p0;
  logic       w_cf_p0;
  logic [7:0] r_result_p1;
  logic       r_cf_p1;

  alu_shifter_comb u_comb (
    .db          (db),
    .op543       (op543),
    .cf_in       (cf_in),
    .shift_enable(shift_enable),
    .result      (w_result_p0),
    .cf          (w_cf_p0)
  );

  // p0 -> p1: outputs clear immediately on reset, so data is reset too
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_result_p1 <= 8'h00;
      r_cf_p1     <= 1'b0;
    end else begin
      r_result_p1 <= w_result_p0;
      r_cf_p1     <= w_cf_p0;
    end
  end

  assign db_in_low  = r_result_p1[3:0];
  assign db_in_high = r_result_p1[7:4];
  assign cf_out     = r_cf_p1;

endmodule

// File: tb/tb_alu_in_shifter.sv
// Directed self-checking bench for alu_in_shifter; op 110 expectations
// follow ALU_SHIFTER_SLL_EN.
module tb_alu_in_shifter;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] db;
  logic [2:0] op543;
  logic       cf_in;
  logic       shift_enable;
  logic [3:0] db_in_low;
  logic [3:0] db_in_high;
  logic       cf_out;

  int n_checks = 0;
  int n_fail   = 0;

  alu_in_shifter dut (
    .clk         (clk),
    .reset       (reset),
    .db          (db),
    .op543       (op543),
    .cf_in       (cf_in),
    .shift_enable(shift_enable),
    .db_in_low   (db_in_low),
    .db_in_high  (db_in_high),
    .cf_out      (cf_out)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    // assert asynchronously mid-cycle with a non-zero result pending
    @(posedge clk); #2;
    reset = 1'b0; db = 8'hFF; op543 = 3'b000; shift_enable = 1'b1; cf_in = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1; #1;
    n_checks++;
    if ({db_in_high, db_in_low, cf_out} !== 9'h000) begin
      n_fail++;
      $display("FAIL reset_async got=%h exp=000", {db_in_high, db_in_low, cf_out});
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({db_in_high, db_in_low, cf_out} !== 9'h000) begin
      n_fail++;
      $display("FAIL reset_held got=%h exp=000", {db_in_high, db_in_low, cf_out});
    end
    reset = 1'b0; db = 8'h55; op543 = 3'b011; cf_in = 1'b1; #1;
    n_checks++;
    if ({db_in_high, db_in_low, cf_out} !== 9'h000) begin
      n_fail++;
      $display("FAIL reset_release_pre_edge got=%h exp=000", {db_in_high, db_in_low, cf_out});
    end
    @(posedge clk); #1;
    n_checks++;
    // RR of 55 with cf_in=1 -> aa, carry = db[0] = 1
    if ({db_in_high, db_in_low} !== 8'hAA || cf_out !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_edge got=%h/%b exp=aa/1", {db_in_high, db_in_low}, cf_out);
    end
  endtask

  task automatic test_passthrough();
    logic [7:0] vals [3];
    vals[0] = 8'h55; vals[1] = 8'hC3; vals[2] = 8'h0F;
    for (int i = 0; i < 3; i++) begin
      shift_enable = 1'b0; db = vals[i]; op543 = 3'(i + 5); cf_in = i[0] ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (db_in_low !== vals[i][3:0] || db_in_high !== vals[i][7:4] || cf_out !== (i[0] ? 1'b0 : 1'b1)) begin
        n_fail++;
        $display("FAIL passthrough[%0d] got=%h%h/%b exp=%h/%b", i, db_in_high, db_in_low, cf_out,
                 vals[i], (i[0] ? 1'b0 : 1'b1));
      end
    end
  endtask

  // exp_res holds op 000 in bits 63:56 ... op 111 in bits 7:0; exp_cf bit 7 is op 000
  task automatic test_ops(input string name, input logic [7:0] d, input logic c,
                          input logic [63:0] exp_res, input logic [7:0] exp_cf);
    for (int i = 0; i < 8; i++) begin
      shift_enable = 1'b1; db = d; cf_in = c; op543 = 3'(i);
      @(posedge clk); #1;
      n_checks++;
      if ({db_in_high, db_in_low} !== exp_res[8*(7-i) +: 8] || cf_out !== exp_cf[7-i]) begin
        n_fail++;
        $display("FAIL %s op=%0d got=%h/%b exp=%h/%b", name, i, {db_in_high, db_in_low}, cf_out,
                 exp_res[8*(7-i) +: 8], exp_cf[7-i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    // no idle cycles: each edge must reflect exactly the previous cycle's inputs
    logic [7:0] d [4];
    logic [2:0] o [4];
    logic [7:0] e [4];
    logic       ec [4];
    d[0] = 8'h81; o[0] = 3'b000; e[0] = 8'h03; ec[0] = 1'b1;
    d[1] = 8'h81; o[1] = 3'b111; e[1] = 8'h40; ec[1] = 1'b1;
    d[2] = 8'hF0; o[2] = 3'b101; e[2] = 8'hF8; ec[2] = 1'b0;
    d[3] = 8'h3C; o[3] = 3'b100; e[3] = 8'h78; ec[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      shift_enable = 1'b1; cf_in = 1'b0; db = d[i]; op543 = o[i];
      @(posedge clk); #1;
      n_checks++;
      if ({db_in_high, db_in_low} !== e[i] || cf_out !== ec[i]) begin
        n_fail++;
        $display("FAIL back_to_back[%0d] got=%h/%b exp=%h/%b", i, {db_in_high, db_in_low}, cf_out, e[i], ec[i]);
      end
    end
  endtask

  initial begin
    reset = 1'b1; db = 8'h00; op543 = 3'b000; cf_in = 1'b0; shift_enable = 1'b0;
    #1;
    n_checks++;
    if ({db_in_high, db_in_low, cf_out} !== 9'h000) begin
      n_fail++;
      $display("FAIL initial_reset got=%h exp=000", {db_in_high, db_in_low, cf_out});
    end
    test_reset();
    test_passthrough();
`ifdef ALU_SHIFTER_SLL_EN
    test_ops("ops_55_c0", 8'h55, 1'b0, 64'haaaaaa2aaa2aab2a, 8'b01010101);
    test_ops("ops_55_c1", 8'h55, 1'b1, 64'haaaaabaaaa2aab2a, 8'b01010101);
    test_ops("ops_01_c0", 8'h01, 1'b0, 64'h0280020002000300, 8'b01010101);
    test_ops("ops_01_c1", 8'h01, 1'b1, 64'h0280038002000300, 8'b01010101);
    test_ops("ops_80_c0", 8'h80, 1'b0, 64'h01400040_00c00140, 8'b10101010);
    test_ops("ops_80_c1", 8'h80, 1'b1, 64'h014001c000c00140, 8'b10101010);
`else
    test_ops("ops_55_c0", 8'h55, 1'b0, 64'haaaaaa2aaa2aaa2a, 8'b01010101);
    test_ops("ops_55_c1", 8'h55, 1'b1, 64'haaaaabaaaa2aaa2a, 8'b01010101);
    test_ops("ops_01_c0", 8'h01, 1'b0, 64'h0280020002000200, 8'b01010101);
    test_ops("ops_01_c1", 8'h01, 1'b1, 64'h0280038002000200, 8'b01010101);
    test_ops("ops_80_c0", 8'h80, 1'b0, 64'h01400040_00c00040, 8'b10101010);
    test_ops("ops_80_c1", 8'h80, 1'b1, 64'h014001c000c00040, 8'b10101010);
`endif
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_in_shifter.md
# alu_in_shifter

Input shifter stage of the A-Z80 ALU: takes the 8-bit internal data bus and optionally applies one of the eight Z80 CB-prefix rotate/shift operations before the value enters the ALU core. It presents the result as separate low and high nibbles and produces the bit shifted out as the new carry. Results are registered, so the block is one pipeline stage between the data bus and the ALU nibble datapath.

## Interface
Parameters: none.
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- db  input  8  data bus value to be shifted
- op543  input  3  operation select (opcode bits 5:4:3)
- cf_in  input  1  current carry flag, inserted by RL/RR
- shift_enable  input  1  1 = apply operation, 0 = pass-through
- db_in_low  output  4  result bits 3:0 (registered)
- db_in_high  output  4  result bits 7:4 (registered)
- cf_out  output  1  carry after shifting (registered)

## Operation
- op543[0] = 0 selects left shift, 1 selects right shift.
- Left: result = {db[6:0], ins}, cf_out = db[7]. Right: result = {ins, db[7:1]}, cf_out = db[0].
- Inserted bit ins by op543: 000 RLC = db[7]; 001 RRC = db[0]; 010 RL = cf_in; 011 RR = cf_in; 100 SLA = 0; 101 SRA = db[7]; 110 SLL = 1; 111 SRL = 0.
- shift_enable = 0: result = db unchanged, cf_out = cf_in; op543 ignored.
- db_in_low = result[3:0], db_in_high = result[7:4].
- No other flags are computed here.

## Timing
- All three outputs are registered: inputs sampled at rising edge N appear on outputs after edge N; latency exactly 1 cycle, throughput 1 per cycle.
- No handshake; every cycle samples new inputs.
- Reset asserted (any time, asynchronously): db_in_low = 0, db_in_high = 0, cf_out = 0 immediately; the held values persist until the first rising edge after reset deasserts.
- Inputs changing mid-cycle have no effect until the next edge; there are no X-propagation exceptions for unused op encodings (all eight are defined).

## Configuration
- Macro ALU_SHIFTER_SLL_EN.
- Defined: op543 = 110 (with shift_enable = 1) is SLL, inserted bit = 1 (undocumented Z80 behaviour).
- Not defined: op543 = 110 behaves identically to SLA (inserted bit = 0); cf_out still = db[7].

## Structure
- Shared package alu_pkg: enum shift_op_t {RLC=0, RRC, RL, RR, SLA, SRA, SLL, SRL} (3 bits) and helper constant for left/right decode (bit 0).
- One combinational sub-module alu_shifter_comb (db, op543, cf_in, shift_enable -> result[7:0], cf) instantiated by alu_in_shifter, which adds the output register and reset.

## Test plan
- Reset: assert reset with db = 8'hFF, shift_enable = 1 -> outputs 0 immediately and held through clock edges; deassert -> first edge loads new result.
- Pass-through: shift_enable = 0, db = 8'h55, cf_in = 1 -> after one edge result 8'h55 (low 5, high 5), cf_out = 1.
- db = 8'h55, cf_in = 0, ops 000..111 -> results aa, aa, aa, 2a, aa, 2a, ab, 2a; with cf_in = 1 -> aa, aa, ab, aa, aa, 2a, ab, 2a.
- db = 8'h01, cf_in = 0 -> 02, 80, 02, 00, 02, 00, 03, 00 (cf_out 0,1,0,1,0,1,0,1); cf_in = 1 -> RL = 03, RR = 80.
- db = 8'h80, cf_in = 0 -> 01, 40, 00, 40, 00, c0, 01, 40 (cf_out 1,0,1,0,1,0,1,0); cf_in = 1 -> RL = 01, RR = c0.
- Build without ALU_SHIFTER_SLL_EN: db = 8'h01, op 110 -> 02, cf_out = 0; db = 8'h55 -> aa.
